// File: rtl/sc_hex_display.sv
// sc_hex_display: sequential double-dabble binary-to-BCD converter driving active-low 7-segment digits.
// Define SC_HEX_LEADING_ZERO_BLANK_EN to blank digits above the most significant non-zero digit.
module sc_hex_display #(
    parameter int DIGITS = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           value_in,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SC_HEX_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    state_t              state_q;
    logic [31:0]         bin_q, last_q;
    logic [39:0]         bcd_q, adj_d;
    logic [4:0]          cnt_q;
    logic                pending_q, busy_q, overflow_q, ovf_d, lead;
    logic [7*DIGITS-1:0] hex_q, hex_d;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = DASH;
        endcase
    endfunction

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < 10; i++)
            adj_d[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    end

    // Nibbles above DIGITS only matter as an overflow flag; display uses the low DIGITS.
    always_comb begin
        ovf_d = 1'b0;
        for (int i = DIGITS; i < 10; i++)
            if (bcd_q[4*i+:4] != 4'd0) ovf_d = 1'b1;
        hex_d = '1;
        lead  = LZB;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead = lead && bcd_q[4*k+:4] == 4'd0 && k != 0;
            hex_d[7*k+:7] = ovf_d ? DASH : lead ? BLANK : seg(bcd_q[4*k+:4]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            hex_q      <= '1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            last_q     <= '0;
            pending_q  <= 1'b1;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (pending_q || value_in != last_q) begin
                    state_q <= LOAD;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    bin_q     <= value_in;
                    last_q    <= value_in;
                    bcd_q     <= '0;
                    cnt_q     <= '0;
                    pending_q <= 1'b0;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {adj_d[38:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= UPDATE;
                end
                UPDATE: begin
                    hex_q      <= hex_d;
                    overflow_q <= ovf_d;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign hex      = hex_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
endmodule
